// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous value commit.
// Optional leading-zero suppression is enabled by defining SEG7_LEADZERO_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] din,
  output logic [3:0]  char,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic        pending,
  output logic        frame_done
);

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      shadow;
  logic [15:0]      active;
  logic             digit_hidden;

  // Pure register mux: only moves when digit_sel or active change, both on entry to BLANK.
  assign char = active[{digit_sel, 2'b00} +: 4];

`ifdef SEG7_LEADZERO_BLANK_EN
  // A digit is suppressed when it and every more-significant nibble are zero; digit 0 always shows.
  assign digit_hidden = (digit_sel != 2'd0) && ((active >> {digit_sel, 2'b00}) == 16'h0);
`else
  assign digit_hidden = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK;
      cnt        <= '0;
      digit_sel  <= 2'd0;
      an         <= 4'b1111;
      shadow     <= 16'h0;
      active     <= 16'h0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (load) begin
        shadow  <= din;
        pending <= 1'b1;
      end

      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= ON;
            cnt   <= '0;
            an    <= digit_hidden ? 4'b1111 : ~(4'b0001 << digit_sel);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ON: begin
          if (cnt == ON_LAST) begin
            state     <= BLANK;
            cnt       <= '0;
            an        <= 4'b1111;
            digit_sel <= digit_sel + 2'd1;
            if (digit_sel == 2'd3) begin
              frame_done <= 1'b1;
              // Commit takes the pre-edge shadow; a coincident load stays pending for the next frame.
              if (pending) begin
                active <= shadow;
                if (!load) begin
                  pending <= 1'b0;
                end
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= BLANK;
          cnt   <= '0;
          an    <= 4'b1111;
        end
      endcase
    end
  end

endmodule
